// File: rtl/muladd_pkg.sv
// muladd_pkg: shared state type and parameter helpers for the sequential multiply-add
package muladd_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} muladd_state_t;
   function automatic int muladd_steps(input int b_width, input int chunk);
      return b_width / chunk;
   endfunction
   function automatic bit muladd_chunk_ok(input int b_width, input int chunk);
      return (chunk > 0) && (b_width % chunk == 0);
   endfunction
endpackage

// File: rtl/muladd_step.sv
// muladd_step: one signed (A+1)x(CHUNK+1) partial product, shifted and added to the accumulator
module muladd_step #(
   parameter int A_WIDTH = 52,
   parameter int CHUNK = 17,
   parameter int R_WIDTH = 86,
   parameter int SH_W = 7
) (
   input  logic [A_WIDTH-1:0] a_i,
   input  logic               a_signed_i,
   input  logic [CHUNK-1:0]   b_i,
   input  logic               b_signed_i,
   input  logic [SH_W-1:0]    shift_i,
   input  logic [R_WIDTH-1:0] acc_i,
   output logic [R_WIDTH-1:0] acc_o
);
   localparam int P_W = A_WIDTH + CHUNK + 2;
   localparam int E_W = (R_WIDTH > P_W) ? R_WIDTH : P_W;
   logic signed [A_WIDTH:0] a_x;
   logic signed [CHUNK:0]   b_x;
   logic signed [P_W-1:0]   a_e, b_e, pp;
   logic signed [E_W-1:0]   pp_e;
   // The extra top bit lets unsigned operands ride through a signed multiplier
   assign a_x = {a_signed_i & a_i[A_WIDTH-1], a_i};
   assign b_x = {b_signed_i & b_i[CHUNK-1], b_i};
   assign a_e = P_W'(a_x);
   assign b_e = P_W'(b_x);
   assign pp = a_e * b_e;
   assign pp_e = E_W'(pp);
   assign acc_o = acc_i + (pp_e[R_WIDTH-1:0] << shift_i);
endmodule

// File: rtl/muladd_seq.sv
// muladd_seq: multi-cycle src1*src2+addend, walking src2 one CHUNK slice per cycle
module muladd_seq
   import muladd_pkg::*;
#(
   parameter int A_WIDTH = 52,
   parameter int B_WIDTH = 34,
   parameter int CHUNK = 17,
   localparam int R_WIDTH = A_WIDTH + B_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_signed_a,
   input  logic               in_signed_b,
   input  logic [A_WIDTH-1:0] in_src1,
   input  logic [B_WIDTH-1:0] in_src2,
   input  logic [R_WIDTH-1:0] in_addend,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [R_WIDTH-1:0] out_result,
   output logic               busy
);
   localparam int STEPS = muladd_steps(B_WIDTH, CHUNK);
   localparam int ST_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam int SH_W = $clog2(R_WIDTH);
   if (!muladd_chunk_ok(B_WIDTH, CHUNK)) begin : g_bad_chunk
      $error("muladd_seq: B_WIDTH must be a multiple of CHUNK");
   end
   muladd_state_t      state_q;
   logic [ST_W-1:0]    step_q;
   logic [A_WIDTH-1:0] a_q;
   logic [B_WIDTH-1:0] b_q;
   logic               sa_q, sb_q, vld_q, last, accept;
   logic [R_WIDTH-1:0] acc_q, acc_d, res_q;
   logic [SH_W-1:0]    off;
   logic [CHUNK-1:0]   slice;
   assign last = step_q == ST_W'(STEPS - 1);
   assign off = SH_W'(int'(step_q) * CHUNK);
   assign slice = CHUNK'(b_q >> off);
   assign in_ready = !reset && !flush && (state_q == IDLE || (state_q == DONE && out_ready));
   assign accept = in_valid && in_ready;
   assign out_valid = vld_q;
   assign out_result = res_q;
   assign busy = state_q != IDLE;
   // Only the top slice carries src2's sign; lower slices are plain magnitude digits
   muladd_step #(.A_WIDTH(A_WIDTH), .CHUNK(CHUNK), .R_WIDTH(R_WIDTH), .SH_W(SH_W)) u_step (
      .a_i(a_q), .a_signed_i(sa_q), .b_i(slice), .b_signed_i(sb_q & last),
      .shift_i(off), .acc_i(acc_q), .acc_o(acc_d)
   );
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         step_q <= '0;
         a_q <= '0;
         b_q <= '0;
         sa_q <= 1'b0;
         sb_q <= 1'b0;
         acc_q <= '0;
         res_q <= '0;
         vld_q <= 1'b0;
      end else if (flush) begin
         state_q <= IDLE;
         vld_q <= 1'b0;
      end else if (accept) begin
         a_q <= in_src1;
         b_q <= in_src2;
         sa_q <= in_signed_a;
         sb_q <= in_signed_b;
         acc_q <= in_addend;
         step_q <= '0;
         state_q <= RUN;
         vld_q <= 1'b0;
      end else if (state_q == RUN) begin
         acc_q <= acc_d;
         step_q <= last ? '0 : step_q + 1'b1;
         if (last) begin
            state_q <= DONE;
            res_q <= acc_d;
            vld_q <= 1'b1;
         end
      end else if (state_q == DONE && out_ready) begin
         state_q <= IDLE;
         vld_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_muladd_seq.sv
// tb_muladd_seq: scoreboard bench for muladd_seq at default parameters
module tb_muladd_seq;
   localparam int A = 52, B = 34, C = 17, R = 86, STEPS = 2;
   logic clk, reset, flush, in_valid, in_ready, in_signed_a, in_signed_b;
   logic [A-1:0] in_src1;
   logic [B-1:0] in_src2;
   logic [R-1:0] in_addend, out_result;
   logic out_valid, out_ready, busy;
   logic [R-1:0] exp_q[$];
   int checks = 0, errors = 0;

   muladd_seq dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_signed_a(in_signed_a), .in_signed_b(in_signed_b), .in_src1(in_src1),
      .in_src2(in_src2), .in_addend(in_addend), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [R-1:0] model(input logic [A-1:0] a, input logic [B-1:0] b,
                                          input logic [R-1:0] c, input bit sa, input bit sb);
      logic [R-1:0] ax, bx;
      ax = sa ? R'($signed(a)) : R'(a);
      bx = sb ? R'($signed(b)) : R'(b);
      return ax * bx + c;
   endfunction

   task automatic issue(input logic [A-1:0] a, input logic [B-1:0] b, input logic [R-1:0] c,
                        input bit sa, input bit sb, input bit push, input logic [R-1:0] e);
      int n = 0;
      in_valid = 1'b1; in_src1 = a; in_src2 = b; in_addend = c;
      in_signed_a = sa; in_signed_b = sb;
      @(negedge clk);
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_timeout in_ready=%b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (push) exp_q.push_back(e);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (lat < 20) begin
         @(posedge clk); @(negedge clk); lat++;
         if (out_valid === 1'b1) break;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_signed_a = 1'b0; in_signed_b = 1'b0; in_src1 = '0; in_src2 = '0; in_addend = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, busy, in_ready} !== 3'b000 || out_result !== '0) begin
         errors++; $display("FAIL reset_state v/b/r=%b%b%b res=%h want 000 res=0", out_valid, busy, in_ready, out_result);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready in_ready=%b want 1", in_ready); end
      @(posedge clk); #1;
   endtask

   typedef struct {logic [A-1:0] a; logic [B-1:0] b; logic [R-1:0] c; bit sa; bit sb; logic [R-1:0] e;} vec_t;

   task automatic test_arith;
      vec_t v[4];
      logic [R-1:0] one = 1, r;
      int lat;
      v[0] = '{A'(3), B'(5), R'(7), 1'b0, 1'b0, R'(22)};
      v[1] = '{'1, '1, '0, 1'b1, 1'b1, R'(1)};
      v[2] = '{A'(0) - A'(2), B'(1) << 33, '0, 1'b1, 1'b0, R'(0) - (one << 34)};
      v[3] = '{'1, '1, '1, 1'b0, 1'b0, R'(0) - (one << 52) - (one << 34)};
      foreach (v[i]) begin
         issue(v[i].a, v[i].b, v[i].c, v[i].sa, v[i].sb, 1'b1, v[i].e);
         wait_valid(lat);
         checks++;
         if (lat + 1 !== STEPS + 1) begin errors++; $display("FAIL latency_%0d got %0d want %0d", i, lat + 1, STEPS + 1); end
         r = exp_q.size() ? exp_q.pop_front() : 'x;
         checks++;
         if (out_result !== r) begin errors++; $display("FAIL arith_%0d got %h want %h", i, out_result, r); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random;
      logic [A-1:0] a;
      logic [B-1:0] b;
      logic [R-1:0] c, r;
      bit sa, sb;
      int lat;
      for (int k = 0; k < 24; k++) begin
         a = A'({$urandom, $urandom}); b = B'({$urandom, $urandom});
         c = R'({$urandom, $urandom, $urandom});
         sa = 1'($urandom); sb = 1'($urandom);
         if (k % 6 == 5) a = '1;
         if (k % 8 == 7) b = B'(1) << (B - 1);
         issue(a, b, c, sa, sb, 1'b1, model(a, b, c, sa, sb));
         wait_valid(lat);
         r = exp_q.size() ? exp_q.pop_front() : 'x;
         checks++;
         if (out_valid !== 1'b1 || out_result !== r) begin
            errors++; $display("FAIL random_%0d sa=%b sb=%b got %h want %h", k, sa, sb, out_result, r);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back;
      logic [R-1:0] e1, e2, r;
      int lat;
      e1 = model(A'(12345), B'(678), R'(9), 1'b0, 1'b0);
      e2 = model('1, B'(1000), R'(5), 1'b1, 1'b0);
      out_ready = 1'b0;
      issue(A'(12345), B'(678), R'(9), 1'b0, 1'b0, 1'b1, e1);
      wait_valid(lat);
      in_valid = 1'b1; in_src1 = '1; in_src2 = B'(1000); in_addend = R'(5);
      in_signed_a = 1'b1; in_signed_b = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (out_valid !== 1'b1 || out_result !== e1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL hold_%0d v=%b rdy=%b res=%h want v=1 rdy=0 res=%h", k, out_valid, in_ready, out_result, e1);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready in_ready=%b want 1", in_ready); end
      r = exp_q.size() ? exp_q.pop_front() : 'x;
      checks++;
      if (out_result !== r) begin errors++; $display("FAIL b2b_first got %h want %h", out_result, r); end
      exp_q.push_back(e2);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(lat);
      checks++;
      if (lat + 1 !== STEPS + 1) begin errors++; $display("FAIL b2b_latency got %0d want %0d", lat + 1, STEPS + 1); end
      r = exp_q.size() ? exp_q.pop_front() : 'x;
      checks++;
      if (out_result !== r) begin errors++; $display("FAIL b2b_second got %h want %h", out_result, r); end
      @(posedge clk); #1;
   endtask

   task automatic test_flush;
      bit seen = 1'b0;
      int lat;
      issue(A'(77), B'(99), R'(1), 1'b0, 1'b0, 1'b0, '0);
      flush = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready in_ready=%b want 0", in_ready); end
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL flush_idle rdy=%b busy=%b want 1 0", in_ready, busy); end
      for (int k = 0; k < 6; k++) begin
         if (out_valid !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen) begin errors++; $display("FAIL flush_run out_valid rose=1 want 0"); end
      @(posedge clk); #1;
      issue(A'(5), B'(6), R'(0), 1'b0, 1'b0, 1'b0, '0);
      wait_valid(lat);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_done v=%b busy=%b want 0 0", out_valid, busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_done;
      logic [R-1:0] r;
      int lat;
      out_ready = 1'b0;
      issue(A'(1000), B'(2000), R'(3), 1'b0, 1'b0, 1'b0, '0);
      wait_valid(lat);
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({out_valid, busy, in_ready} !== 3'b000 || out_result !== '0) begin
         errors++; $display("FAIL reset_async v/b/r=%b%b%b res=%h want 000 res=0", out_valid, busy, in_ready, out_result);
      end
      @(posedge clk); #1;
      reset = 1'b0; out_ready = 1'b1;
      issue(A'(11), B'(13), R'(17), 1'b0, 1'b0, 1'b1, R'(160));
      wait_valid(lat);
      r = exp_q.size() ? exp_q.pop_front() : 'x;
      checks++;
      if (out_result !== r) begin errors++; $display("FAIL after_reset got %h want %h", out_result, r); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset;
      test_arith;
      test_random;
      test_back_to_back;
      test_flush;
      test_reset_done;
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left %0d entries want 0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/muladd_seq.md
# muladd_seq

Parametrised, multi-cycle signed/unsigned multiply-add unit computing `src1 * src2 + addend`. It walks `src2` in `CHUNK`-bit slices, one slice per cycle, through a narrow multiply-accumulate step. Each operation is accepted and returned with valid/ready handshakes, and a synchronous flush aborts it. It is the generalised successor of the fixed-width partial-product combiners in the integer multiplier path and serves the core's MUL/MULH/MAC issue.

## Interface

- `A_WIDTH`, 52, width of `src1`.
- `B_WIDTH`, 34, width of `src2`; must be a multiple of `CHUNK`.
- `CHUNK`, 17, `src2` slice width consumed per cycle.
- `R_WIDTH`, derived localparam, equals `A_WIDTH + B_WIDTH`; width of the addend and the result.
- `STEPS`, derived localparam, equals `B_WIDTH / CHUNK`.

Ports:

- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-high.
- `flush` in 1: synchronous abort of any operation in flight.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when high together with `in_valid`.
- `in_signed_a` in 1: interpret `src1` as two's complement.
- `in_signed_b` in 1: interpret `src2` as two's complement.
- `in_src1` in `A_WIDTH`: multiplicand.
- `in_src2` in `B_WIDTH`: multiplier.
- `in_addend` in `R_WIDTH`: value added to the product.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer ready.
- `out_result` out `R_WIDTH`: `(src1*src2 + addend) mod 2^R_WIDTH`.
- `busy` out 1: high in RUN or DONE.

## Operation

- FSM states:
  - IDLE: `in_ready = !flush && !reset`.
  - RUN: step counter runs 0..`STEPS`-1.
  - DONE: result held.
- Accept (`in_valid && in_ready`):
  - Register `src1`, `src2`, `addend` and both sign flags.
  - Set `acc <= addend` and `step <= 0`, then go to RUN.
- RUN, each cycle:
  - Slice `s = src2[step*CHUNK +: CHUNK]`.
  - Treat the slice as unsigned, except the top slice (`step == STEPS-1`), which is signed when `in_signed_b`.
  - Extend `src1` by one bit: sign-extend when `in_signed_a`, zero-extend otherwise.
  - Partial product: signed `(A_WIDTH+1) x (CHUNK+1)` multiply.
  - Update: `acc <= acc + (pp << step*CHUNK)` mod `2^R_WIDTH`.
  - After the top slice, go to DONE.
- DONE:
  - `out_valid = 1` and `out_result = acc`, held stable while `out_ready` is low.
  - On `out_ready`, go to IDLE, or straight to RUN if a new request is accepted in the same cycle.
- Back-to-back: `in_ready = (IDLE || (DONE && out_ready)) && !flush`.
- Arithmetic: all four sign combinations are exact within `R_WIDTH` before the addend; the addend sum wraps modulo `2^R_WIDTH`, with no overflow flag.
- `flush` has priority over every other event:
  - Next state is IDLE and `out_valid` drops next cycle.
  - An operation in flight is discarded with no output.
  - No request is accepted in the flush cycle.
  - A result pending in DONE is discarded even if `out_ready` is high in the same cycle.
- `reset` at any time forces IDLE.
  - Reset values: `out_valid = 0`, `out_result = 0`, `busy = 0`, `in_ready = 0` while asserted.
  - `acc`, operands and `step` clear to 0.

## Timing

- Latency: accept in cycle T, `out_valid` high from cycle T+`STEPS`+1 (T+3 at defaults).
- Throughput: one operation per `STEPS`+1 cycles with `out_ready` held high.
- Inputs are sampled only in the accept cycle; they are don't-care otherwise.
- `out_result` changes only on the transition into DONE or on reset.
- The output side is registered. `in_ready` is combinational from state, `out_ready` and `flush`; there is no combinational path from `in_*` to `out_*`.

## Structure

- Package `muladd_pkg`:
  - State enum `muladd_state_t` (IDLE/RUN/DONE).
  - Function `muladd_steps(B_WIDTH, CHUNK)`.
  - Elaboration check that `B_WIDTH % CHUNK == 0`.
- Sub-module `muladd_step`:
  - Purely combinational signed `(A_WIDTH+1) x (CHUNK+1)` multiply, shift by the step offset, and add to an `R_WIDTH` accumulator.
  - Parametrised by `A_WIDTH`, `CHUNK` and `R_WIDTH`.
- Top `muladd_seq`: FSM, step counter, operand/accumulator registers, handshakes.

## Test plan

1. **Unsigned basic.** `src1=3`, `src2=5`, `addend=7`, both sign flags 0.
   - `out_result=22`.
   - `out_valid` rises exactly 3 cycles after the accept.
2. **Signed x signed.** `src1 = 2^52-1` (−1), `src2 = 2^34-1` (−1), `addend=0`, both signed.
   - `out_result = 1`.
3. **Signed x unsigned.** `src1 = 2^52-2` (−2), `src2 = 2^33`, `in_signed_a=1`, `in_signed_b=0`.
   - `out_result = 2^86 - 2^34`.
4. **Wrap.** Unsigned `src1 = 2^52-1`, `src2 = 2^34-1`, `addend = 2^86-1`.
   - `out_result = 2^86 - 2^52 - 2^34`.
5. **Backpressure and back-to-back.**
   - Hold `out_ready=0` for 5 cycles: `out_result` stays stable and `in_ready=0`.
   - Then raise `out_ready` with `in_valid=1` in the same cycle: the new request is accepted and its result appears 3 cycles later.
6. **Flush and reset.**
   - `flush` in RUN step 0: `out_valid` never rises and `in_ready=1` the following cycle.
   - `reset` asserted in DONE: `out_valid`, `out_result` and `busy` go to 0 immediately, asynchronously.
